mc_main_fsm: RTL

//  Main controller FSM for the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/mc_ctrl_pkg.sv | 58 +++++
 rtl/mc_main_fsm_if.sv | 33 +++
 rtl/mc_out_decode.sv | 81 ++++++++
 rtl/mc_main_fsm.sv | 93 +++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller:
// state codes, supported opcodes, datapath mux selects and the control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Result mux
    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_DATA     = 2'b01;
    localparam logic [1:0] RES_ALURES   = 2'b10;
    // ALU-A mux
    localparam logic [1:0] SRCA_PC      = 2'b00;
    localparam logic [1:0] SRCA_OLDPC   = 2'b01;
    localparam logic [1:0] SRCA_RD1     = 2'b10;
    // ALU-B mux
    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_IMM     = 2'b01;
    localparam logic [1:0] SRCB_FOUR    = 2'b10;
    // ALU decoder hint
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Per-state control word; pc_update and branch are combined with the
    // zero flag in the FSM to form pc_write.
    typedef struct packed {
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mc_main_fsm_if.sv
// Controller <-> datapath bundle: opcode/flags/handshake in, selects and enables out.
interface mc_main_fsm_if #(
    parameter int OP_W = 7
);
    logic [OP_W-1:0] op;
    logic            zero;
    logic            mem_ready;
    logic [1:0]      result_src;
    logic [1:0]      alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic            adr_src;
    logic            ir_write;
    logic            mem_write;
    logic            reg_write;
    logic            pc_write;
    logic            illegal_op;
    logic [3:0]      state_o;

    // Controller side
    modport master (
        input  op, zero, mem_ready,
        output result_src, alu_src_a, alu_src_b, alu_op, adr_src,
               ir_write, mem_write, reg_write, pc_write, illegal_op, state_o
    );

    // Datapath side
    modport slave (
        output op, zero, mem_ready,
        input  result_src, alu_src_a, alu_src_b, alu_op, adr_src,
               ir_write, mem_write, reg_write, pc_write, illegal_op, state_o
    );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode: state (plus mem_ready for the fetch handshake) -> control word.
module mc_out_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Everything defaults low; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        case (state_t'(state))
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                // IR load and PC+4 only when the instruction word is actually there
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch target PC+imm while the opcode is decoded
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                // Held for the whole state so memory sees a stable write until it acks
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                // OldPC+4 is the link value; PC takes the target held in ALUOut
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main multicycle controller: next-state logic, reset gating of all outputs,
// and pc_write / illegal_op formation. Output decode lives in mc_out_decode.
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 7,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    mc_main_fsm_if.master  bus
);

    logic [3:0] state_q, state_d;
    logic       mem_rdy;
    logic       illegal;
    logic [6:0] opc;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign opc     = bus.op[6:0];

    // Next-state selection; unsupported opcodes drop back to FETCH and flag illegal
    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_t'(state_q))
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opc == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;   // ALUWB, MEMWB, BEQ and unused codes
        endcase
    end

    // State register with synchronous active-low reset to FETCH
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl)
    );

    // Drive the bus; everything is held low while reset is asserted so an
    // in-flight write cannot complete during the reset cycle.
    always_comb begin
        bus.result_src = '0;
        bus.alu_src_a  = '0;
        bus.alu_src_b  = '0;
        bus.alu_op     = '0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.pc_write   = 1'b0;
        bus.illegal_op = 1'b0;
        bus.state_o    = '0;
        if (reset_n) begin
            bus.result_src = ctrl.result_src;
            bus.alu_src_a  = ctrl.alu_src_a;
            bus.alu_src_b  = ctrl.alu_src_b;
            bus.alu_op     = ctrl.alu_op;
            bus.adr_src    = ctrl.adr_src;
            bus.ir_write   = ctrl.ir_write;
            bus.mem_write  = ctrl.mem_write;
            bus.reg_write  = ctrl.reg_write;
            bus.pc_write   = ctrl.pc_update | (ctrl.branch & bus.zero);
            bus.illegal_op = illegal;
            bus.state_o    = state_q;
        end
    end

endmodule
